// File: rtl/rv32i_fetch_unit.sv
// Decoupled RV32I fetch front end: owns the fetch PC, issues word requests, queues {pc, inst} for decode.
// Latency: a memory response is visible at the queue head the cycle after it arrives (never bypassed).
// Backpressure: requests are credit-limited by in-flight count plus queue occupancy; decode stalls via inst_ready.
//
// Ports:
//   clk, reset (async, active low)
//   imem_req_valid/ready/addr   : word fetch request to instruction memory
//   imem_rsp_valid/data         : in-order responses, one per accepted request
//   redirect_valid/redirect_pc  : restart fetch at a new target, flushing the queue
//   inst_valid/ready/data/pc    : queue head handed to decode
//   outstanding                 : accepted-but-unanswered request count
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    output logic                                   imem_req_valid,
    input  logic                                   imem_req_ready,
    output logic [31:0]                            imem_req_addr,
    input  logic                                   imem_rsp_valid,
    input  logic [31:0]                            imem_rsp_data,
    input  logic                                   redirect_valid,
    input  logic [31:0]                            redirect_pc,
    output logic                                   inst_valid,
    input  logic                                   inst_ready,
    output logic [31:0]                            inst_data,
    output logic [31:0]                            inst_pc,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_discard;
    logic [31:0]   r_q_data [DEPTH];
    logic [31:0]   r_q_pc   [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_req_vld;
    logic          w_acc;
    logic          w_rsp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_head_vld;
    logic [31:0]   w_redir_pc;

    // Credit: every in-flight request already owns a queue slot, so a push can never find the queue full.
    assign w_req_vld  = reset && !redirect_valid
                      && (32'(r_outstanding) < MAX_OUTSTANDING)
                      && ((32'(r_outstanding) + 32'(r_count)) < DEPTH);
    assign w_acc      = w_req_vld && imem_req_ready;
    assign w_rsp      = imem_rsp_valid;
    // Responses to requests issued before a redirect are stale until discard drains to zero.
    assign w_drop     = w_rsp && (r_discard != '0);
    assign w_push     = w_rsp && (r_discard == '0) && !redirect_valid;
    assign w_head_vld = (r_count != '0);
    assign w_pop      = w_head_vld && inst_ready && !redirect_valid;
    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req_valid = w_req_vld;
    assign imem_req_addr  = r_fetch_pc;
    assign inst_valid     = w_head_vld;
    assign inst_data      = r_q_data[r_rd_ptr];
    assign inst_pc        = r_q_pc[r_rd_ptr];
    assign outstanding    = r_outstanding;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else begin
            // No request is accepted during a redirect, so this holds on both paths.
            r_outstanding <= r_outstanding + OW'(w_acc) - OW'(w_rsp);
            if (redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
                r_rsp_pc   <= w_redir_pc;
                // A response landing this cycle is already dropped, so it needs no discard credit.
                r_discard  <= r_outstanding - OW'(w_rsp);
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_acc) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_drop) begin
                    r_discard <= r_discard - OW'(1);
                end
                if (w_push) begin
                    r_q_data[r_wr_ptr] <= imem_rsp_data;
                    r_q_pc[r_wr_ptr]   <= r_rsp_pc;
                    r_wr_ptr           <= r_wr_ptr + AW'(1);
                    r_rsp_pc           <= r_rsp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_push && !w_pop && (r_count == CW'(DEPTH))));

    a_discard_bound: assert property (@(posedge clk) disable iff (!reset)
        (r_discard <= r_outstanding) && (32'(r_outstanding) <= MAX_OUTSTANDING));

    a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
        !(w_rsp && (r_outstanding == '0)));

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
module tb_rv32i_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [1:0]  outstanding;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    rv32i_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .outstanding(outstanding)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // One clock: sample handshakes before the edge, then advance the in-order memory model.
    task automatic tick();
        logic        acc;
        logic        rspv;
        logic [31:0] a;
        #1;
        acc  = imem_req_valid && imem_req_ready;
        a    = imem_req_addr;
        rspv = imem_rsp_valid;
        @(posedge clk);
        #1;
        cyc++;
        if (rspv && mq_addr.size() > 0) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (acc) begin
            mq_addr.push_back(a);
            mq_due.push_back(cyc + lat);
        end
        if (mq_addr.size() > 0 && mq_due[0] <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mdata(mq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mq_addr.delete();
        mq_due.delete();
        #10;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
        total++; if (inst_data !== 32'h0) begin bad++; $display("FAIL rst_inst_data got=%h exp=0", inst_data); end
        total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_req_addr got=%h exp=0", imem_req_addr); end
        do_reset();
        total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin bad++; $display("FAIL rst_first_req got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_basic();
        do_reset();
        lat = 1;
        tick();
        total++; if (outstanding !== 2'd1) begin bad++; $display("FAIL basic_out1 got=%0d exp=1", outstanding); end
        total++; if (imem_req_addr !== 32'h4) begin bad++; $display("FAIL basic_addr got=%h exp=00000004", imem_req_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL basic_no_bypass got=%b exp=0", inst_valid); end
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'(4 * k), mdata(32'(4 * k))}) begin
                bad++; $display("FAIL basic_stream k=%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst_data, 32'(4 * k), mdata(32'(4 * k)));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat = 1;
        inst_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 2) begin
                total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL bp_req_still got=%b exp=1", imem_req_valid); end
            end
            if (i == 3) begin
                total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_drop got=%b exp=0", imem_req_valid); end
            end
            if (i >= 1) begin
                total++;
                if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h0, mdata(32'h0)}) begin
                    bad++; $display("FAIL bp_head_hold i=%0d got=%b/%h/%h exp=1/00000000/%h", i, inst_valid, inst_pc, inst_data, mdata(32'h0));
                end
            end
        end
        total++; if ({imem_req_valid, outstanding, imem_req_addr} !== {1'b0, 2'd0, 32'h10}) begin bad++; $display("FAIL bp_stalled got=%b/%0d/%h exp=0/0/00000010", imem_req_valid, outstanding, imem_req_addr); end
        inst_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'(4 * k), mdata(32'(4 * k))}) begin
                bad++; $display("FAIL bp_drain k=%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst_data, 32'(4 * k), mdata(32'(4 * k)));
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        lat = 1;
        inst_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0302;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if ({inst_valid, outstanding} !== {1'b0, 2'd0}) begin bad++; $display("FAIL flush_empty got=%b/%0d exp=0/0", inst_valid, outstanding); end
        total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h300}) begin bad++; $display("FAIL flush_req got=%b/%h exp=1/00000300", imem_req_valid, imem_req_addr); end
        tick();
        tick();
        total++; if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h300, mdata(32'h300)}) begin bad++; $display("FAIL flush_first got=%b/%h/%h exp=1/00000300/%h", inst_valid, inst_pc, inst_data, mdata(32'h300)); end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        lat = 3;
        tick();
        tick();
        total++; if ({outstanding, imem_req_valid} !== {2'd2, 1'b0}) begin bad++; $display("FAIL rinf_pre got=%0d/%b exp=2/0", outstanding, imem_req_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if ({outstanding, inst_valid, imem_req_addr} !== {2'd2, 1'b0, 32'h100}) begin bad++; $display("FAIL rinf_post got=%0d/%b/%h exp=2/0/00000100", outstanding, inst_valid, imem_req_addr); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                total++; if (outstanding !== 2'd1) begin bad++; $display("FAIL rinf_drop1 got=%0d exp=1", outstanding); end
            end
            if (i < 4) begin
                total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rinf_stale i=%0d got=%b/%h exp=0", i, inst_valid, inst_pc); end
            end else begin
                total++; if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h100, mdata(32'h100)}) begin bad++; $display("FAIL rinf_first got=%b/%h/%h exp=1/00000100/%h", inst_valid, inst_pc, inst_data, mdata(32'h100)); end
            end
        end
        tick();
        total++; if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h104, mdata(32'h104)}) begin bad++; $display("FAIL rinf_second got=%b/%h/%h exp=1/00000104/%h", inst_valid, inst_pc, inst_data, mdata(32'h104)); end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        lat = 1;
        tick();
        total++; if (outstanding !== 2'd1) begin bad++; $display("FAIL rsc_pre got=%0d exp=1", outstanding); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if ({inst_valid, outstanding} !== {1'b0, 2'd0}) begin bad++; $display("FAIL rsc_empty got=%b/%0d exp=0/0", inst_valid, outstanding); end
        total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h200}) begin bad++; $display("FAIL rsc_req got=%b/%h exp=1/00000200", imem_req_valid, imem_req_addr); end
        tick();
        total++; if ({inst_valid, outstanding} !== {1'b0, 2'd1}) begin bad++; $display("FAIL rsc_issue got=%b/%0d exp=0/1", inst_valid, outstanding); end
        tick();
        total++; if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h200, mdata(32'h200)}) begin bad++; $display("FAIL rsc_first got=%b/%h/%h exp=1/00000200/%h", inst_valid, inst_pc, inst_data, mdata(32'h200)); end
    endtask

    task automatic test_wrap();
        do_reset();
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_start got=%h exp=fffffffc", imem_req_addr); end
        tick();
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=00000000", imem_req_addr); end
        tick();
        total++; if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'hFFFF_FFFC, mdata(32'hFFFF_FFFC)}) begin bad++; $display("FAIL wrap_last got=%b/%h/%h exp=1/fffffffc/%h", inst_valid, inst_pc, inst_data, mdata(32'hFFFF_FFFC)); end
        tick();
        total++; if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h0, mdata(32'h0)}) begin bad++; $display("FAIL wrap_pc got=%b/%h/%h exp=1/00000000/%h", inst_valid, inst_pc, inst_data, mdata(32'h0)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 1;
        inst_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL rmid_full got=%b exp=1", inst_valid); end
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        mq_addr.delete();
        mq_due.delete();
        #1;
        total++; if ({inst_valid, imem_req_valid, outstanding} !== {1'b0, 1'b0, 2'd0}) begin bad++; $display("FAIL rmid_clear got=%b/%b/%0d exp=0/0/0", inst_valid, imem_req_valid, outstanding); end
        total++; if ({inst_data, inst_pc} !== 64'h0) begin bad++; $display("FAIL rmid_head got=%h/%h exp=0/0", inst_data, inst_pc); end
        #9;
        reset      = 1'b1;
        inst_ready = 1'b1;
        #1;
        total++; if ({imem_req_valid, imem_req_addr, outstanding} !== {1'b1, 32'h0, 2'd0}) begin bad++; $display("FAIL rmid_restart got=%b/%h/%0d exp=1/00000000/0", imem_req_valid, imem_req_addr, outstanding); end
        tick();
        total++; if ({outstanding, imem_req_addr} !== {2'd1, 32'h4}) begin bad++; $display("FAIL rmid_issue got=%0d/%h exp=1/00000004", outstanding, imem_req_addr); end
        tick();
        total++; if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h0, mdata(32'h0)}) begin bad++; $display("FAIL rmid_first got=%b/%h/%h exp=1/00000000/%h", inst_valid, inst_pc, inst_data, mdata(32'h0)); end
    endtask

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        #7;
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
